// File: rtl/multihit_encoder.sv
// multihit_encoder
//   Registered, valid/ready index encoder for an N-bit request vector.
//   Modes: 00 strict one-hot (lowest index plus multi-hit error),
//          01 highest-priority index,
//          10 serialise every set bit, lowest first,
//          11 serialise every set bit, highest first.
//   A zero vector always produces one beat with out_hit=0.
//
// Ports
//   vccd1, vssd1  power/ground (USE_POWER_PINS only)
//   wb_clk_i      clock, rising edge
//   wb_rst_i      synchronous active-high reset
//   in_vec        request vector
//   in_mode       mode select
//   in_valid      request valid
//   in_ready      block can accept a request (IDLE, not in reset)
//   out_idx       emitted bit index
//   out_hit       1 when out_idx refers to a set bit
//   out_err       strict mode: captured vector had more than one bit set
//   out_count     popcount of captured vector
//   out_last      final beat for the captured vector
//   out_valid     output beat valid
//   out_ready     downstream accepts beat
module multihit_encoder #(
  parameter int unsigned N = 64,
  localparam int unsigned K = $clog2(N)
) (
`ifdef USE_POWER_PINS
  inout  wire           vccd1,
  inout  wire           vssd1,
`endif
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [N-1:0]  in_vec,
  input  logic [1:0]    in_mode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [K-1:0]  out_idx,
  output logic          out_hit,
  output logic          out_err,
  output logic [K:0]    out_count,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e       r_state;
  logic [N-1:0] r_pending;
  logic [1:0]   r_mode;
  logic [K:0]   r_count;

  state_e       w_state_d;
  logic [N-1:0] w_pending_d;
  logic [1:0]   w_mode_d;
  logic [K:0]   w_count_d;

  logic [K-1:0] w_lo_idx;
  logic [K-1:0] w_hi_idx;
  logic [K-1:0] w_sel_idx;
  logic [K:0]   w_popcount;
  logic         w_emit;
  logic         w_nonzero;
  logic         w_at_most_one;
  logic         w_last;
  logic [N-1:0] w_clear_mask;

  // Lowest and highest set bit of the pending vector; both 0 when pending is empty.
  always_comb begin
    w_lo_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lo_idx = K'(i);
    end
  end

  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_pending[i]) w_hi_idx = K'(i);
    end
  end

  // Summed at K+1 bits so an all-ones vector does not wrap.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_popcount = w_popcount + (K+1)'(in_vec[i]);
    end
  end

  assign w_emit        = (r_state == StEmit);
  assign w_nonzero     = |r_pending;
  // True for zero or exactly one pending bit.
  assign w_at_most_one = ((r_pending & (r_pending - N'(1))) == '0);
  // mode[0] picks the high end (01 priority-high, 11 descending).
  assign w_sel_idx     = r_mode[0] ? w_hi_idx : w_lo_idx;
  // Single-beat modes always finish in one beat; serial modes finish on the last pending bit.
  assign w_last        = r_mode[1] ? w_at_most_one : 1'b1;
  assign w_clear_mask  = N'(1) << w_sel_idx;

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending;
    w_mode_d    = r_mode;
    w_count_d   = r_count;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_pending_d = in_vec;
          w_mode_d    = in_mode;
          w_count_d   = w_popcount;
          w_state_d   = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (w_last) begin
            w_pending_d = '0;
            w_state_d   = StIdle;
          end else begin
            w_pending_d = r_pending & ~w_clear_mask;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_mode    <= 2'b00;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_mode    <= w_mode_d;
      r_count   <= w_count_d;
    end
  end

  // Outputs decode registered state only; no in_* to out_* path.
  assign in_ready  = (r_state == StIdle) & ~wb_rst_i;
  assign out_valid = w_emit;
  assign out_idx   = w_emit ? w_sel_idx : '0;
  assign out_hit   = w_emit & w_nonzero;
  assign out_err   = w_emit & (r_mode == 2'b00) & (r_count > (K+1)'(1));
  assign out_last  = w_emit & w_last;
  assign out_count = r_count;

endmodule

// File: tb/tb_multihit_encoder.sv
module tb_multihit_encoder;

  localparam int N = 64;
  localparam int K = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_vec;
  logic [1:0]    in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  out_idx;
  logic          out_hit;
  logic          out_err;
  logic [K:0]    out_count;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multihit_encoder #(.N(N)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_vec    (in_vec),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_hit   (out_hit),
    .out_err   (out_err),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    int idx;
    bit hit;
    bit err;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_count;

  // Reference: list the set bit positions, then order/select them by mode.
  function automatic void model_fill(input logic [N-1:0] vec, input logic [1:0] mode);
    int    bits[$];
    beat_t bt;
    exp_q.delete();
    for (int i = 0; i < N; i++) if (vec[i]) bits.push_back(i);
    exp_count = bits.size();
    if (bits.size() == 0) begin
      bt.idx = 0; bt.hit = 0; bt.err = 0; bt.last = 1;
      exp_q.push_back(bt);
    end else if (mode == 2'd0) begin
      bt.idx = bits[0]; bt.hit = 1; bt.err = (bits.size() > 1); bt.last = 1;
      exp_q.push_back(bt);
    end else if (mode == 2'd1) begin
      bt.idx = bits[bits.size()-1]; bt.hit = 1; bt.err = 0; bt.last = 1;
      exp_q.push_back(bt);
    end else begin
      if (mode == 2'd3) bits.reverse();
      for (int j = 0; j < bits.size(); j++) begin
        bt.idx = bits[j]; bt.hit = 1; bt.err = 0; bt.last = (j == bits.size() - 1);
        exp_q.push_back(bt);
      end
    end
  endfunction

  // Submit one vector and follow its whole stream. stall_beat/stall_len holds out_ready low
  // for stall_len cycles on that beat; rand_stall adds random back-pressure.
  task automatic run_vector(input logic [N-1:0] vec, input logic [1:0] mode,
                            input int stall_beat, input int stall_len, input bit rand_stall,
                            input string name);
    bit acc;
    int stall_left;
    int consec;
    model_fill(vec, mode);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    in_vec = vec; in_mode = mode; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Garbage request held valid during the stream must be ignored.
    in_vec = {$urandom, $urandom}; in_mode = 2'($urandom);
    consec = 0;
    for (int b = 0; b < exp_q.size(); b++) begin
      stall_left = (b == stall_beat) ? stall_len : 0;
      do begin
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s beat%0d handshake: got valid=%b in_ready=%b want valid=1 in_ready=0",
                   name, b, out_valid, in_ready);
        end
        n_cmp++;
        if (out_idx !== K'(exp_q[b].idx) || out_hit !== exp_q[b].hit ||
            out_err !== exp_q[b].err || out_last !== exp_q[b].last ||
            out_count !== (K+1)'(exp_count)) begin
          n_fail++;
          $display("FAIL %s beat%0d: got idx=%0d hit=%b err=%b last=%b count=%0d want idx=%0d hit=%b err=%b last=%b count=%0d",
                   name, b, out_idx, out_hit, out_err, out_last, out_count,
                   exp_q[b].idx, exp_q[b].hit, exp_q[b].err, exp_q[b].last, exp_count);
        end
        if (stall_left > 0) begin
          acc = 0; stall_left--;
        end else if (rand_stall && consec < 3 && $urandom_range(0, 2) == 0) begin
          acc = 0; consec++;
        end else begin
          acc = 1; consec = 0;
        end
        out_ready = acc;
        @(posedge clk);
        @(negedge clk);
      end while (!acc);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after last: got valid=%b in_ready=%b want valid=0 in_ready=1",
               name, out_valid, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_mode = 2'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_idx !== '0 || out_hit !== 1'b0 ||
        out_err !== 1'b0 || out_last !== 1'b0 || out_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b idx=%0d hit=%b err=%b last=%b cnt=%0d want all 0",
               in_ready, out_valid, out_idx, out_hit, out_err, out_last, out_count);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_strict_priority();
    logic [N-1:0] v;
    v = '0; v[37] = 1'b1;
    run_vector(v, 2'd0, -1, 0, 0, "strict_onehot37");
    v = '0; v[3] = 1'b1; v[5] = 1'b1;
    run_vector(v, 2'd0, -1, 0, 0, "strict_multihit");
    run_vector(v, 2'd1, -1, 0, 0, "priority_35");
  endtask

  task automatic test_serial();
    logic [N-1:0] v;
    v = '0; v[0] = 1'b1; v[2] = 1'b1; v[63] = 1'b1;
    run_vector(v, 2'd2, -1, 0, 0, "serial_asc");
    // Beat 1 of descending order is index 2.
    run_vector(v, 2'd3, 1, 2, 0, "serial_desc_stall");
  endtask

  task automatic test_zero();
    for (int m = 0; m < 4; m++) run_vector('0, 2'(m), -1, 0, 0, "zero_vec");
  endtask

  task automatic test_reset_mid_emit();
    logic [N-1:0] ones;
    ones = '1;
    @(negedge clk);
    in_vec = ones; in_mode = 2'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== K'(b) || out_last !== 1'b0 ||
          out_count !== (K+1)'(64)) begin
        n_fail++;
        $display("FAIL midreset beat%0d: got v=%b idx=%0d last=%b cnt=%0d want v=1 idx=%0d last=0 cnt=64",
                 b, out_valid, out_idx, out_last, out_count, b);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_idx !== '0 || out_hit !== 1'b0 || out_err !== 1'b0 ||
        out_last !== 1'b0 || out_count !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset outputs: got v=%b idx=%0d hit=%b err=%b last=%b cnt=%0d rdy=%b want all 0",
               out_valid, out_idx, out_hit, out_err, out_last, out_count, in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset release: got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    run_vector(ones, 2'd1, -1, 0, 0, "priority_allones");
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = '0;
        repeat ($urandom_range(1, 4)) v[$urandom_range(0, N-1)] = 1'b1;
      end else begin
        v = {$urandom, $urandom};
      end
      run_vector(v, 2'($urandom), -1, 0, 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_strict_priority();
    test_serial();
    test_zero();
    test_reset_mid_emit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multihit_encoder.md
# multihit_encoder

Registered, handshaked, parametrised successor to the combinational one-hot-to-binary encoder. It accepts an N-bit request vector and emits bit indices on a valid/ready stream. Four modes are supported: strict one-hot with multi-hit error flag, highest-priority single index, and serialisation of every set bit in ascending or descending order. It sits in the user project area between the raw `io_in` request lines and downstream consumers that need one index per transfer.

## Interface
- `N`, 64, request vector width; any N ≥ 2. Derived localparam `K = $clog2(N)`.
- `vccd1`, `vssd1`  inout  1  power/ground, present only under `USE_POWER_PINS`
- `wb_clk_i`  input  1  single clock; all state updates on rising edge
- `wb_rst_i`  input  1  synchronous, active-high reset
- `in_vec`  input  N  request vector
- `in_mode`  input  2  00 strict, 01 priority-high, 10 serial-ascending, 11 serial-descending
- `in_valid`  input  1  request vector/mode valid
- `in_ready`  output  1  block can accept a request
- `out_idx`  output  K  emitted bit index
- `out_hit`  output  1  1 = `out_idx` refers to a set bit; 0 = captured vector was all zeros
- `out_err`  output  1  strict mode only: captured vector had more than one bit set
- `out_count`  output  K+1  popcount of captured vector (0..N)
- `out_last`  output  1  final beat for the captured vector
- `out_valid`  output  1  output beat valid
- `out_ready`  input  1  downstream accepts beat

## Operation
- States: IDLE, EMIT.
- IDLE: `in_ready`=1 (0 while `wb_rst_i`=1), `out_valid`=0. On `in_valid & in_ready`, the block captures `in_vec` into a pending register, latches `in_mode`, and computes `out_count`=popcount. It then goes to EMIT.
- EMIT: `in_ready`=0 and `out_valid`=1. Beat contents per mode:
  - 00: one beat. `out_idx` = lowest set bit; `out_err` = (count>1); `out_last`=1.
  - 01: one beat. `out_idx` = highest set bit; `out_err`=0; `out_last`=1.
  - 10: one beat per set bit, lowest first. On each accepted beat, that bit is cleared from pending. `out_last`=1 when exactly one pending bit remains.
  - 11: same as 10, but highest first.
- Zero vector, any mode: exactly one beat with `out_hit`=0, `out_idx`=0, `out_count`=0, `out_err`=0, `out_last`=1.
- `out_hit`=1 on every beat of a non-zero vector.
- `out_err` is 0 in modes 01/10/11.
- When a beat with `out_last`=1 is accepted (`out_valid & out_ready`), the state returns to IDLE.
- While `out_valid & !out_ready`, all `out_*` stay stable and pending is unchanged.
- `out_count` and the latched mode stay constant across all beats of one vector.
- Arithmetic: popcount is summed at K+1 bits, so N=64 all-ones yields 64 without overflow. Index encoding uses a K-bit binary position; index N-1 must be representable.

## Timing
- Reset (`wb_rst_i`=1 at an edge): state=IDLE, pending=0, `out_valid`=0, `out_idx`=0, `out_hit`=0, `out_err`=0, `out_last`=0, `out_count`=0. `in_ready`=0 while reset is high and 1 in the first cycle after release.
- Reset mid-EMIT: the outstanding stream is abandoned with no partial `out_last`. `out_valid`=0 from the cycle after the reset edge.
- Latency: a request accepted at edge T presents its first beat in cycle T+1 (registered outputs; no combinational `in_*`→`out_*` path).
- Throughput: with `out_ready` held at 1, there is one beat per cycle. A vector with P set bits (P≥1, serial mode) occupies cycles T+1..T+P. `in_ready`=1 in cycle T+P+1.
- `in_ready` does not depend combinationally on `out_ready`. There is no overlap between consecutive vectors.
- `in_vec`/`in_mode` changes while `in_ready`=0 are ignored.

## Test plan
- Reset, then mode 00, `in_vec`=1<<37 → one beat at T+1: idx=37, hit=1, err=0, count=1, last=1; `in_ready`=1 at T+2.
- Mode 00, bits {3,5} → idx=3, err=1, count=2, last=1. Same vector in mode 01 → idx=5, err=0.
- Mode 10, bits {0,2,63}, `out_ready`=1 → idx 0,2,63 in cycles T+1..T+3, last only on 63, count=3 throughout, `in_ready`=1 at T+4.
- Mode 11, same vector, `out_ready`=0 for 2 cycles while idx=2 is shown → beats 63,2,2,2,0 with outputs stable during the stall, last on 0.
- `in_vec`=0 in each mode → single beat hit=0, idx=0, count=0, err=0, last=1.
- Mode 10, all-ones: accept 10 beats (idx 0..9), then assert `wb_rst_i` for one cycle → `out_valid`=0 next cycle, all outputs 0, `in_ready`=1 after release. Then mode 01 all-ones → idx=63, count=64.
